// File: rtl/ps2_joy_mapper_pkg.sv
// Shared types and constants for the PS/2 + joystick player mapper.
// KEY_MAP holds the default keyboard layout for players 0 and 1.
package ps2_joy_pkg;

   // Control functions a key or joystick bit can drive
   typedef enum logic [3:0] {
      F_UP, F_DOWN, F_LEFT, F_RIGHT,
      F_BTN0, F_BTN1, F_BTN2, F_BTN3, F_BTN4, F_BTN5, F_BTN6, F_BTN7,
      F_START, F_COIN, F_PAUSE, F_SERVICE
   } func_e;

   // One keyboard binding: {extended flag, scancode} -> player/function
   typedef struct packed {
      logic       ext;
      logic [7:0] code;
      logic [1:0] player;
      func_e      fn;
   } key_map_t;

   localparam int KEY_MAP_N = 21;

   localparam key_map_t KEY_MAP [KEY_MAP_N] = '{
      // player 0: extended arrows, ctrl/alt/space, 1 start, 5 coin, p pause, 9 service
      '{1'b1, 8'h75, 2'd0, F_UP},
      '{1'b1, 8'h72, 2'd0, F_DOWN},
      '{1'b1, 8'h6B, 2'd0, F_LEFT},
      '{1'b1, 8'h74, 2'd0, F_RIGHT},
      '{1'b0, 8'h14, 2'd0, F_BTN0},
      '{1'b0, 8'h11, 2'd0, F_BTN1},
      '{1'b0, 8'h29, 2'd0, F_BTN2},
      '{1'b0, 8'h16, 2'd0, F_START},
      '{1'b0, 8'h2E, 2'd0, F_COIN},
      '{1'b0, 8'h4D, 2'd0, F_PAUSE},
      '{1'b0, 8'h46, 2'd0, F_SERVICE},
      // player 1: R/F/D/G directions, a/s/q buttons, 2 start, 6 coin, 0 service
      '{1'b0, 8'h2D, 2'd1, F_UP},
      '{1'b0, 8'h2B, 2'd1, F_DOWN},
      '{1'b0, 8'h23, 2'd1, F_LEFT},
      '{1'b0, 8'h34, 2'd1, F_RIGHT},
      '{1'b0, 8'h1C, 2'd1, F_BTN0},
      '{1'b0, 8'h1B, 2'd1, F_BTN1},
      '{1'b0, 8'h15, 2'd1, F_BTN2},
      '{1'b0, 8'h1E, 2'd1, F_START},
      '{1'b0, 8'h36, 2'd1, F_COIN},
      '{1'b0, 8'h45, 2'd1, F_SERVICE}
   };

   // Autofire prescaler length in clk cycles
   localparam int AF_DIV = 65536;

   // Fixed joystick bit positions; the rest follow the button field
   localparam int JOY_RIGHT = 0;
   localparam int JOY_LEFT  = 1;
   localparam int JOY_DOWN  = 2;
   localparam int JOY_UP    = 3;
   localparam int JOY_BTN0  = 4;

   function automatic int joy_start(input int nb);
      return JOY_BTN0 + nb;
   endfunction

   function automatic int joy_coin(input int nb);
      return JOY_BTN0 + nb + 1;
   endfunction

   function automatic int joy_pause(input int nb);
      return JOY_BTN0 + nb + 2;
   endfunction

   function automatic int joy_service(input int nb);
      return JOY_BTN0 + nb + 3;
   endfunction

endpackage

// File: rtl/ps2_joy_mapper_if.sv
// Bus bundle between hps_io (master) and the player mapper (slave).
// With PS2_JOY_AUTOFIRE_EN defined the autofire mask/rate also travel here.
interface ps2_joy_mapper_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int NUM_BUTTONS = 3
);
   localparam int PW = 7 + NUM_BUTTONS;

   logic [10:0]                  ps2_key;
   logic [32*NUM_PLAYERS-1:0]    joystick;
   logic [PW*NUM_PLAYERS-1:0]    players;
   logic [NUM_PLAYERS-1:0]       service;
`ifdef PS2_JOY_AUTOFIRE_EN
   logic [NUM_BUTTONS*NUM_PLAYERS-1:0] af_mask;
   logic [3:0]                   af_rate;

   modport master (output ps2_key, joystick, af_mask, af_rate, input players, service);
   modport slave  (input ps2_key, joystick, af_mask, af_rate, output players, service);
`else
   modport master (output ps2_key, joystick, input players, service);
   modport slave  (input ps2_key, joystick, output players, service);
`endif
endinterface

// File: rtl/ps2_joy_mapper_coin_stretch.sv
// Coin pulse stretcher: every rising edge of the source holds the coin
// output high for at least COIN_HOLD cycles; a new edge restarts the hold.
module coin_stretch #(
   parameter int COIN_HOLD = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic src,
   output logic coin
);
   localparam int CW = $clog2(COIN_HOLD + 1);

   logic          src_q;
   logic [CW-1:0] cnt;

   // Edge detect and reload-on-edge down counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         src_q <= 1'b0;
         cnt   <= '0;
      end else begin
         src_q <= src;
         if (src && !src_q)
            cnt <= CW'(COIN_HOLD - 1);
         else if (cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end

   // The cycle carrying the edge counts as the first held cycle
   assign coin = src | (cnt != '0);

endmodule

// File: rtl/ps2_joy_mapper.sv
// PS/2 key + hps_io joystick merger producing per-player control vectors.
// Player vector layout: {pause, coin, start, btn[NB-1:0], right, left, down, up}.
// Optional feature macro: PS2_JOY_AUTOFIRE_EN (autofire mask/rate on the bus).
module ps2_joy_mapper
   import ps2_joy_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,      // 1..4, keyboard drives players 0-1 only
   parameter int NUM_BUTTONS = 3,      // 1..8
   parameter int COIN_HOLD   = 65535   // >= 1
) (
   input  logic            clk,
   input  logic            rst_n,
   ps2_joy_mapper_if.slave bus
);
   localparam int NP       = NUM_PLAYERS;
   localparam int NB       = NUM_BUTTONS;
   localparam int PW       = 7 + NB;
   localparam int START_POS = 4 + NB;
   localparam int COIN_POS  = 5 + NB;
   localparam int PAUSE_POS = 6 + NB;

   logic                  toggle_q;
   logic                  key_evt;
   logic [KEY_MAP_N-1:0]  key_state;
   logic [3:0][15:0]      key_fn;
   logic [NP-1:0][PW-1:0] merged;
   logic [NP-1:0]         svc_src;
   logic [NP-1:0]         coin_out;
   logic [NP-1:0][PW-1:0] players_q;
   logic [NP-1:0]         service_q;
   logic                  btn;
   logic                  unused_bits;

   // A key event is any change of the hps_io toggle strobe
   assign key_evt = (bus.ps2_key[10] != toggle_q);

   // Track the strobe (also in reset, so release is silent) and latch mapped keys
   always_ff @(posedge clk) begin
      toggle_q <= bus.ps2_key[10];
      if (!rst_n) begin
         key_state <= '0;
      end else if (key_evt) begin
         for (int i = 0; i < KEY_MAP_N; i++) begin
            if (bus.ps2_key[8] == KEY_MAP[i].ext && bus.ps2_key[7:0] == KEY_MAP[i].code)
               key_state[i] <= bus.ps2_key[9];
         end
      end
   end

   // Collapse held keys into per-player function flags
   always_comb begin
      key_fn = '0;
      for (int i = 0; i < KEY_MAP_N; i++) begin
         if (key_state[i])
            key_fn[KEY_MAP[i].player][KEY_MAP[i].fn] = 1'b1;
      end
   end

`ifdef PS2_JOY_AUTOFIRE_EN
   localparam int AF_PRE_W = $clog2(AF_DIV);

   logic [AF_PRE_W-1:0] af_pre;
   logic [3:0]          af_cnt;
   logic                af_phase;

   // Free-running autofire timebase: prescaler tick, rate divider, phase flip
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         af_pre   <= '0;
         af_cnt   <= '0;
         af_phase <= 1'b1;
      end else begin
         if (af_pre == AF_PRE_W'(AF_DIV - 1)) begin
            af_pre <= '0;
            if (af_cnt == bus.af_rate) begin
               af_cnt   <= '0;
               af_phase <= ~af_phase;
            end else begin
               af_cnt <= af_cnt + 1'b1;
            end
         end else begin
            af_pre <= af_pre + 1'b1;
         end
      end
   end
`endif

   // OR-merge keyboard and joystick sources per player and function
   always_comb begin
      merged  = '0;
      svc_src = '0;
      btn     = 1'b0;
      for (int p = 0; p < NP; p++) begin
         merged[p][0] = key_fn[p][F_UP]    | bus.joystick[32*p + JOY_UP];
         merged[p][1] = key_fn[p][F_DOWN]  | bus.joystick[32*p + JOY_DOWN];
         merged[p][2] = key_fn[p][F_LEFT]  | bus.joystick[32*p + JOY_LEFT];
         merged[p][3] = key_fn[p][F_RIGHT] | bus.joystick[32*p + JOY_RIGHT];
         for (int b = 0; b < NB; b++) begin
            btn = key_fn[p][int'(F_BTN0) + b] | bus.joystick[32*p + JOY_BTN0 + b];
`ifdef PS2_JOY_AUTOFIRE_EN
            merged[p][4+b] = btn & (bus.af_mask[p*NB + b] ? af_phase : 1'b1);
`else
            merged[p][4+b] = btn;
`endif
         end
         merged[p][START_POS] = key_fn[p][F_START] | bus.joystick[32*p + joy_start(NB)];
         merged[p][COIN_POS]  = key_fn[p][F_COIN]  | bus.joystick[32*p + joy_coin(NB)];
         merged[p][PAUSE_POS] = key_fn[p][F_PAUSE] | bus.joystick[32*p + joy_pause(NB)];
         svc_src[p]           = key_fn[p][F_SERVICE] | bus.joystick[32*p + joy_service(NB)];
      end
   end

   for (genvar p = 0; p < NP; p++) begin : g_coin
      coin_stretch #(
         .COIN_HOLD (COIN_HOLD)
      ) u_coin (
         .clk   (clk),
         .rst_n (rst_n),
         .src   (merged[p][COIN_POS]),
         .coin  (coin_out[p])
      );
   end

   // Output register; the coin bit is replaced by its stretched version
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         players_q <= '0;
         service_q <= '0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            players_q[p]           <= merged[p];
            players_q[p][COIN_POS] <= coin_out[p];
         end
         service_q <= svc_src;
      end
   end

   assign bus.players = players_q;
   assign bus.service = service_q;

   // Joystick bits beyond the mapped layout and keyboard slots of absent players
   assign unused_bits = ^{bus.joystick, key_fn};

endmodule

// File: tb/tb_ps2_joy_mapper.sv
// Scoreboard bench for ps2_joy_mapper (2 players, 3 buttons, COIN_HOLD=8).
// Stimulus pushes hand-computed expectations tagged with the clock edge at
// which they must appear; a negedge monitor pops and compares them.
module tb_ps2_joy_mapper;
   localparam int NP = 2;
   localparam int NB = 3;
   localparam int CH = 8;

   // Player vector bits {pause,coin,start,btn2,btn1,btn0,right,left,down,up}
   localparam logic [9:0] P_UP    = 10'h001;
   localparam logic [9:0] P_RIGHT = 10'h008;
   localparam logic [9:0] P_BTN0  = 10'h010;
   localparam logic [9:0] P_START = 10'h080;
   localparam logic [9:0] P_COIN  = 10'h100;

   typedef struct {
      int          cyc;
      string       name;
      logic [19:0] players;
      logic [1:0]  service;
   } exp_t;

   logic   clk;
   logic   rst_n;
   int     cyc;
   int     n_checks;
   int     n_fail;
   int     mon_i;
   exp_t   sbq[$];

   ps2_joy_mapper_if #(.NUM_PLAYERS(NP), .NUM_BUTTONS(NB)) bus ();

   ps2_joy_mapper #(
      .NUM_PLAYERS (NP),
      .NUM_BUTTONS (NB),
      .COIN_HOLD   (CH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [19:0] pv(input logic [9:0] p1, input logic [9:0] p0);
      return {p1, p0};
   endfunction

   function automatic logic [10:0] key(input logic tg, input logic pr, input logic ex,
                                       input logic [7:0] code);
      return {tg, pr, ex, code};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_at(input int off, input string nm, input logic [19:0] pl,
                         input logic [1:0] sv);
      exp_t e;
      e.cyc     = cyc + off;
      e.name    = nm;
      e.players = pl;
      e.service = sv;
      sbq.push_back(e);
   endtask

   // Monitor: compare every expectation due at this edge, flag stale ones
   always @(negedge clk) begin
      mon_i = 0;
      while (mon_i < sbq.size()) begin
         if (sbq[mon_i].cyc == cyc) begin
            n_checks++;
            if (bus.players !== sbq[mon_i].players || bus.service !== sbq[mon_i].service) begin
               n_fail++;
               $display("FAIL %s cyc=%0d players=%h service=%b expected players=%h service=%b",
                        sbq[mon_i].name, cyc, bus.players, bus.service,
                        sbq[mon_i].players, sbq[mon_i].service);
            end
            sbq.delete(mon_i);
         end else if (sbq[mon_i].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s not checked at cyc=%0d (now cyc=%0d)",
                     sbq[mon_i].name, sbq[mon_i].cyc, cyc);
            sbq.delete(mon_i);
         end else begin
            mon_i++;
         end
      end
   end

   initial begin
      cyc          = 0;
      n_checks     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      bus.ps2_key  = key(1'b1, 1'b1, 1'b1, 8'h75);
      bus.joystick = '0;
`ifdef PS2_JOY_AUTOFIRE_EN
      bus.af_mask  = '0;
      bus.af_rate  = 4'd0;
`endif
      tick(1);                                              // cyc 1
      exp_at(1, "reset_state", '0, 2'b00);
      exp_at(2, "reset_state", '0, 2'b00);
      tick(2);                                              // cyc 3
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) exp_at(k, "release_quiet", '0, 2'b00);
      tick(4);                                              // cyc 7

      // extended up arrow: press then release, 2 clk latency
      bus.ps2_key = key(1'b0, 1'b1, 1'b1, 8'h75);
      exp_at(1, "ext_up_latency", '0, 2'b00);
      exp_at(2, "ext_up_press", pv(10'h0, P_UP), 2'b00);
      tick(2);                                              // cyc 9
      bus.ps2_key = key(1'b1, 1'b0, 1'b1, 8'h75);
      exp_at(1, "ext_up_hold", pv(10'h0, P_UP), 2'b00);
      exp_at(2, "ext_up_release", '0, 2'b00);
      tick(2);                                              // cyc 11

      // keypad 8 shares the code but not the extended bit
      bus.ps2_key = key(1'b0, 1'b1, 1'b0, 8'h75);
      exp_at(1, "kp8_ignored", '0, 2'b00);
      exp_at(2, "kp8_ignored", '0, 2'b00);
      tick(2);                                              // cyc 13

      // repeated press is idempotent
      bus.ps2_key = key(1'b1, 1'b1, 1'b1, 8'h75);
      tick(1);                                              // cyc 14
      bus.ps2_key = key(1'b0, 1'b1, 1'b1, 8'h75);
      exp_at(1, "repeat_press", pv(10'h0, P_UP), 2'b00);
      exp_at(2, "repeat_press", pv(10'h0, P_UP), 2'b00);
      tick(2);                                              // cyc 16
      bus.ps2_key = key(1'b1, 1'b0, 1'b1, 8'h75);
      exp_at(1, "repeat_hold", pv(10'h0, P_UP), 2'b00);
      exp_at(2, "repeat_release", '0, 2'b00);
      tick(2);                                              // cyc 18

      // player 1 'a' -> btn0
      bus.ps2_key = key(1'b0, 1'b1, 1'b0, 8'h1C);
      exp_at(1, "p1_a_latency", '0, 2'b00);
      exp_at(2, "p1_a_press", pv(P_BTN0, 10'h0), 2'b00);
      tick(2);                                              // cyc 20

      // joystick up, then key up takes over as joystick releases
      bus.joystick[3] = 1'b1;
      exp_at(1, "joy_up", pv(P_BTN0, P_UP), 2'b00);
      tick(1);                                              // cyc 21
      bus.ps2_key = key(1'b1, 1'b1, 1'b1, 8'h75);
      exp_at(1, "or_merge", pv(P_BTN0, P_UP), 2'b00);
      tick(1);                                              // cyc 22
      bus.joystick = '0;
      exp_at(1, "or_merge", pv(P_BTN0, P_UP), 2'b00);
      exp_at(2, "or_merge", pv(P_BTN0, P_UP), 2'b00);
      tick(2);                                              // cyc 24

      // unmapped scancode changes nothing
      bus.ps2_key = key(1'b0, 1'b1, 1'b0, 8'h3C);
      exp_at(1, "unmapped", pv(P_BTN0, P_UP), 2'b00);
      exp_at(2, "unmapped", pv(P_BTN0, P_UP), 2'b00);
      tick(2);                                              // cyc 26
      bus.ps2_key = key(1'b1, 1'b0, 1'b1, 8'h75);
      exp_at(1, "up_key_hold", pv(P_BTN0, P_UP), 2'b00);
      exp_at(2, "up_key_release", pv(P_BTN0, 10'h0), 2'b00);
      tick(1);                                              // cyc 27
      bus.ps2_key = key(1'b0, 1'b0, 1'b0, 8'h1C);
      exp_at(2, "p1_a_release", '0, 2'b00);
      tick(2);                                              // cyc 29

      // player 1 coin: one-clock joystick pulse held for CH clocks
      bus.joystick[32 + 5 + NB] = 1'b1;
      for (int k = 0; k <= CH; k++)
         exp_at(k + 1, "coin_stretch", (k < CH) ? pv(P_COIN, 10'h0) : '0, 2'b00);
      tick(1);                                              // cyc 30
      bus.joystick[32 + 5 + NB] = 1'b0;
      tick(10);                                             // cyc 40

      // re-pulse on the 5th held clock restarts the hold
      bus.joystick[32 + 5 + NB] = 1'b1;
      for (int k = 0; k <= 12; k++)
         exp_at(k + 1, "coin_restretch", (k < 12) ? pv(P_COIN, 10'h0) : '0, 2'b00);
      tick(1);                                              // cyc 41
      bus.joystick[32 + 5 + NB] = 1'b0;
      tick(3);                                              // cyc 44
      bus.joystick[32 + 5 + NB] = 1'b1;
      tick(1);                                              // cyc 45
      bus.joystick[32 + 5 + NB] = 1'b0;
      tick(9);                                              // cyc 54

      // joystick mix: p0 right + service, p1 start
      bus.joystick = {32'h0000_0080, 32'h0000_0401};
      exp_at(1, "joy_mix", pv(P_START, P_RIGHT), 2'b01);
      tick(1);                                              // cyc 55
      bus.joystick = '0;
      bus.ps2_key  = key(1'b1, 1'b1, 1'b0, 8'h46);
      exp_at(1, "svc_key_latency", '0, 2'b00);
      exp_at(2, "svc_key", '0, 2'b01);
      tick(2);                                              // cyc 57

      // reset in the middle of a coin stretch
      bus.joystick[5 + NB] = 1'b1;
      exp_at(1, "coin_p0", pv(10'h0, P_COIN), 2'b01);
      tick(1);                                              // cyc 58
      bus.joystick[5 + NB] = 1'b0;
      exp_at(1, "coin_p0_held", pv(10'h0, P_COIN), 2'b01);
      tick(1);                                              // cyc 59
      rst_n = 1'b0;
      exp_at(1, "reset_mid_stretch", '0, 2'b00);
      tick(1);                                              // cyc 60
      rst_n = 1'b1;
      exp_at(1, "after_reset", '0, 2'b00);
      exp_at(2, "after_reset", '0, 2'b00);
      tick(2);                                              // cyc 62

      for (int k = 0; k < 20 && sbq.size() > 0; k++) tick(1);
      if (sbq.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain pending=%0d expected pending=0", sbq.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
